// File: rtl/fifo_gmii_tx.sv
// fifo_gmii_tx
// ------------
// Read-side consumer of the 125 MHz Ethernet TX FIFO (32-bit words, normal
// non-show-ahead read mode).
//
// Operation:
// - Waits until a full burst of BURST_WORDS words is buffered.
// - Drains exactly that burst.
// - Serialises it onto GMII as preamble, SFD, payload (MSB byte of each word
//   first), an optional FCS, and then an enforced inter-frame gap.
//
// Optional feature: define FIFO_GMII_TX_FCS_EN to append a CRC-32 FCS. The
// CRC is the reflected 0x04C11DB7 polynomial, init all-ones, final
// complement, and the LSB byte goes out first. Without the macro the FCS
// state and CRC logic are absent, and DATA goes straight to IFG.
//
// Handshake with the FIFO:
// - fifo_rdreq is a one-clock pulse.
// - fifo_q is valid in the cycle after the pulse and is consumed on the
//   following clock edge.
// - No other flow control exists. The start condition guarantees that the
//   whole burst is already buffered.
//
// Ports:
//   clk           125 MHz clock (also the FIFO read clock)
//   aclr          asynchronous active-high reset
//   enable        allows a new frame to start (sampled in IDLE only)
//   fifo_q        FIFO read data
//   fifo_rdempty  FIFO empty flag
//   fifo_rdfull   FIFO full flag (fifo_rdusedw wraps to 0 when full)
//   fifo_rdusedw  FIFO occupancy
//   fifo_rdreq    FIFO read pulse
//   gmii_txd      GMII transmit byte
//   gmii_txen     GMII transmit enable
//   busy          high in every state except IDLE
//   frame_cnt     completed-frame counter, wraps at 16 bits
//   dbg_state     current FSM state (debug observation)
//
// All outputs are registered.
module fifo_gmii_tx #(
  parameter int BURST_WORDS = 15,  // 15..511
  parameter int IFG_CYCLES  = 12   // >= 1
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        enable,
  input  logic [31:0] fifo_q,
  input  logic        fifo_rdempty,
  input  logic        fifo_rdfull,
  input  logic [8:0]  fifo_rdusedw,
  output logic        fifo_rdreq,
  output logic [7:0]  gmii_txd,
  output logic        gmii_txen,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [2:0]  dbg_state
);

  // IDLE is encoded as 0 so that the reset value of dbg_state reads as idle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
`ifdef FIFO_GMII_TX_FCS_EN
    ST_FCS  = 3'd4,
`endif
    ST_IFG  = 3'd5
  } state_t;

  localparam logic [8:0]  BURST_THR = 9'(BURST_WORDS);
  localparam logic [8:0]  LAST_WORD = 9'(BURST_WORDS - 1);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;        // cycle counter for PRE / FCS / IFG
  logic [1:0]  lane_q, lane_d;      // byte lane of the word now on the wire
  logic [8:0]  widx_q, widx_d;      // index of the word now on the wire
  logic [31:0] word_q, word_d;      // word now being serialised
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        rdreq_q, rdreq_d;
  logic        busy_q, busy_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        start;

`ifdef FIFO_GMII_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs;

  // One byte of the reflected CRC-32, processed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs = ~crc_q;
`endif

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // A full burst is present either by count or by the full flag. The full
  // flag matters because usedw reads 0 at 512 words.
  assign start = enable && (fifo_rdfull || (fifo_rdusedw >= BURST_THR)) && !fifo_rdempty;

  // The next-state logic also computes the outputs for the coming cycle.
  // Because of this, the wire always matches state_q in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    widx_d      = widx_q;
    word_d      = word_q;
    txd_d       = 8'h00;
    txen_d      = 1'b0;
    rdreq_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
`ifdef FIFO_GMII_TX_FCS_EN
    crc_d       = crc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRE;
          cnt_d   = 16'd0;
          txd_d   = 8'h55;
          txen_d  = 1'b1;
        end
      end

      ST_PRE: begin
        txen_d = 1'b1;
        if (cnt_q == 16'd6) begin
          state_d = ST_SFD;
          txd_d   = 8'hD5;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          txd_d   = 8'h55;
          // The first read goes out in the 7th preamble cycle. Its data then
          // arrives during SFD.
          rdreq_d = (cnt_q == 16'd5);
        end
      end

      ST_SFD: begin
        state_d = ST_DATA;
        lane_d  = 2'd0;
        widx_d  = 9'd0;
        word_d  = fifo_q;
        txd_d   = fifo_q[31:24];
        txen_d  = 1'b1;
      end

      ST_DATA: begin
        if (lane_q == 2'd3) begin
          if (widx_q == LAST_WORD) begin
`ifdef FIFO_GMII_TX_FCS_EN
            state_d = ST_FCS;
            cnt_d   = 16'd0;
            txd_d   = fcs[7:0];
            txen_d  = 1'b1;
`else
            state_d     = ST_IFG;
            cnt_d       = 16'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
`endif
          end else begin
            // The next word was read on lane 2, so it is on fifo_q now.
            widx_d = widx_q + 9'd1;
            lane_d = 2'd0;
            word_d = fifo_q;
            txd_d  = fifo_q[31:24];
            txen_d = 1'b1;
          end
        end else begin
          lane_d  = lane_q + 2'd1;
          txd_d   = lane_byte(word_q, lane_q + 2'd1);
          txen_d  = 1'b1;
          rdreq_d = (lane_q == 2'd1) && (widx_q != LAST_WORD);
        end
      end

`ifdef FIFO_GMII_TX_FCS_EN
      ST_FCS: begin
        if (cnt_q == 16'd3) begin
          state_d     = ST_IFG;
          cnt_d       = 16'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          txd_d  = lane_byte(fcs, 2'd2 - cnt_q[1:0]);  // LSB first: 7:0, 15:8, ...
          txen_d = 1'b1;
        end
      end
`endif

      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef FIFO_GMII_TX_FCS_EN
    // The CRC is seeded when a frame begins. It then absorbs every payload
    // byte at the same time that byte is loaded onto the wire.
    if (state_d == ST_PRE) begin
      crc_d = '1;
    end else if (state_d == ST_DATA) begin
      crc_d = crc_byte(crc_q, txd_d);
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      lane_q      <= 2'd0;
      widx_q      <= 9'd0;
      word_q      <= 32'd0;
      txd_q       <= 8'h00;
      txen_q      <= 1'b0;
      rdreq_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
`ifdef FIFO_GMII_TX_FCS_EN
      crc_q       <= '1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      widx_q      <= widx_d;
      word_q      <= word_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      rdreq_q     <= rdreq_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FIFO_GMII_TX_FCS_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign fifo_rdreq = rdreq_q;
  assign gmii_txd   = txd_q;
  assign gmii_txen  = txen_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_gmii_tx.sv
// Testbench for fifo_gmii_tx.
// The FIFO is modelled as a queue with a one-clock read latency.
// Expected wire bytes are built frame by frame from the words pushed, and
// also include the CRC when FIFO_GMII_TX_FCS_EN is defined.
module tb_fifo_gmii_tx;
  localparam int N   = 15;
  localparam int IFG = 12;
`ifdef FIFO_GMII_TX_FCS_EN
  localparam int FCS_B = 4;
`else
  localparam int FCS_B = 0;
`endif
  localparam int WIRE_LEN = 8 + 4 * N + FCS_B;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        aclr = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] fifo_q = 32'd0;
  logic        fifo_rdempty = 1'b1;
  logic        fifo_rdfull = 1'b0;
  logic [8:0]  fifo_rdusedw = 9'd0;
  logic        fifo_rdreq;
  logic [7:0]  gmii_txd;
  logic        gmii_txen;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [2:0]  dbg_state;

  always #4 clk = ~clk;

  fifo_gmii_tx #(.BURST_WORDS(N), .IFG_CYCLES(IFG)) dut (
    .clk          (clk),
    .aclr         (aclr),
    .enable       (enable),
    .fifo_q       (fifo_q),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdfull  (fifo_rdfull),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_rdreq   (fifo_rdreq),
    .gmii_txd     (gmii_txd),
    .gmii_txen    (gmii_txen),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- model state / scoreboard ----------------
  logic [31:0] mem_q[$];   // FIFO contents
  logic [31:0] src_q[$];   // words not yet assigned to an expected frame
  logic [7:0]  exp_q[$];   // expected wire bytes
  logic [7:0]  cap_q[$];   // captured wire bytes
  int          gap_q[$];   // txen-low runs between frames
  int          len_q[$];   // txen-high runs
  int          rd_cnt, hi_run, low_run, underrun;
  bit          rd_prev, txen_prev, seen_high;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic void update_flags();
    fifo_rdempty = (mem_q.size() == 0);
    fifo_rdfull  = (mem_q.size() >= 512);
    fifo_rdusedw = (mem_q.size() >= 512) ? 9'd0 : 9'(mem_q.size());
  endfunction

  function automatic void push_word(input logic [31:0] w);
    mem_q.push_back(w);
    src_q.push_back(w);
    update_flags();
  endfunction

  // One frame on the wire: 7x55, D5, payload MSB-first, optional LSB-first FCS.
  function automatic void add_frame_exp();
    logic [31:0] w, crc;
    logic [7:0]  by;
    crc = '1;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < N; i++) begin
      w = src_q.pop_front();
      for (int b = 3; b >= 0; b--) begin
        by = w[8*b +: 8];
        exp_q.push_back(by);
        crc = crc_upd(crc, by);
      end
    end
    if (FCS_B == 4) begin
      crc = ~crc;
      for (int b = 0; b < 4; b++) exp_q.push_back(crc[8*b +: 8]);
    end
  endfunction

  function automatic int byte_errs();
    int e;
    e = (cap_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic void clear_mon();
    cap_q.delete(); exp_q.delete(); gap_q.delete(); len_q.delete();
    rd_cnt = 0; hi_run = 0; low_run = 0; underrun = 0;
    txen_prev = 1'b0; seen_high = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  // Advances one clock and samples 1 time unit after the edge. The FIFO
  // pops for a read pulse seen in the previous cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (rd_prev) begin
      if (mem_q.size() > 0) fifo_q = mem_q.pop_front();
      else underrun++;
      update_flags();
    end
    rd_prev = fifo_rdreq;
    if (fifo_rdreq) rd_cnt++;
    if (gmii_txen) begin
      cap_q.push_back(gmii_txd);
      if (!txen_prev && seen_high) gap_q.push_back(low_run);
      hi_run++;
      low_run = 0;
      seen_high = 1'b1;
    end else begin
      if (txen_prev) len_q.push_back(hi_run);
      hi_run = 0;
      low_run++;
    end
    txen_prev = gmii_txen;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_txen(input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      step();
      cyc++;
      if (gmii_txen) ok = 1'b1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (frame_cnt == 16'(target) && !busy) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    enable = 1'b0;
    mem_q.delete(); src_q.delete();
    fifo_q = 32'd0;
    rd_prev = 1'b0;
    update_flags();
    run(3);
    aclr = 1'b0;
    clear_mon();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ok; int cyc, e;
    aclr = 1'b1;
    enable = 1'b1;
    mem_q.delete(); src_q.delete();
    rd_prev = 1'b0;
    for (int i = 0; i < N + 3; i++) push_word($urandom());
    clear_mon();
    run(4);
    checks++; if (gmii_txen !== 1'b0) $display("FAIL reset_txen: got %0b want 0", gmii_txen); else passed++;
    checks++; if (gmii_txd !== 8'h00) $display("FAIL reset_txd: got %02h want 00", gmii_txd); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passed++;
    checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0 (IDLE)", dbg_state); else passed++;
    checks++; if (rd_cnt != 0 || fifo_rdreq !== 1'b0) $display("FAIL reset_rdreq: got %0d pulses want 0", rd_cnt); else passed++;
    aclr = 1'b0;
    wait_txen(3, ok, cyc);
    checks++; if (!ok || cyc != 1) $display("FAIL reset_release_start: txen after %0d clk (seen=%0b) want 1", cyc, ok); else passed++;
    wait_frames(1, 300, ok);
    checks++; if (!ok) $display("FAIL reset_frame_done: frame_cnt=%0d busy=%0b want 1/0", frame_cnt, busy); else passed++;
    add_frame_exp();
    e = byte_errs();
    checks++; if (e != 0) $display("FAIL reset_bytes: %0d errors, got %0d bytes want %0d", e, cap_q.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_single_frame();
    bit ok; int cyc, e;
    logic [31:0] crc;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < N; i++) push_word(32'h0001_0203 + 32'h0404_0404 * i);
    wait_txen(5, ok, cyc);
    checks++; if (!ok || cyc != 1 || gmii_txd !== 8'h55) $display("FAIL single_start: cyc=%0d txd=%02h want 1/55", cyc, gmii_txd); else passed++;
    wait_frames(1, 300, ok);
    checks++; if (!ok) $display("FAIL single_done: frame_cnt=%0d busy=%0b want 1/0", frame_cnt, busy); else passed++;
    checks++; if (frame_cnt !== 16'd1) $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); else passed++;
    checks++; if (rd_cnt != N) $display("FAIL single_rdreq: got %0d want %0d", rd_cnt, N); else passed++;
    checks++; if (len_q.size() != 1 || len_q[0] != WIRE_LEN) $display("FAIL single_txen_len: got %0d want %0d", (len_q.size() > 0) ? len_q[0] : -1, WIRE_LEN); else passed++;
    add_frame_exp();
    e = byte_errs();
    checks++; if (e != 0) $display("FAIL single_bytes: %0d errors, got %0d bytes want %0d", e, cap_q.size(), exp_q.size()); else passed++;
`ifdef FIFO_GMII_TX_FCS_EN
    crc = '1;
    for (int i = 8; i < cap_q.size(); i++) crc = crc_upd(crc, cap_q[i]);
    checks++; if (crc !== 32'hDEBB_20E3) $display("FAIL single_fcs_residue: got %08h want debb20e3", crc); else passed++;
`else
    crc = 32'd0;
`endif
  endtask

  task automatic test_threshold();
    bit ok; int e;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < N - 1; i++) push_word($urandom());
    run(40);
    checks++; if (cap_q.size() != 0 || busy !== 1'b0 || rd_cnt != 0) $display("FAIL thr_no_start: bytes=%0d busy=%0b rd=%0d want 0/0/0", cap_q.size(), busy, rd_cnt); else passed++;
    push_word($urandom());
    step();
    checks++; if (gmii_txen !== 1'b1) $display("FAIL thr_start: txen=%0b want 1", gmii_txen); else passed++;
    wait_frames(1, 300, ok);
    add_frame_exp();
    e = byte_errs();
    checks++; if (!ok || e != 0 || rd_cnt != N) $display("FAIL thr_frame: done=%0b errors=%0d rd=%0d want 1/0/%0d", ok, e, rd_cnt, N); else passed++;
    // FIFO completely full: usedw reads 0 and only the full flag signals the burst.
    do_reset();
    for (int i = 0; i < 512; i++) push_word($urandom());
    enable = 1'b1;
    step();
    checks++; if (gmii_txen !== 1'b1) $display("FAIL full_start: txen=%0b want 1 (usedw=%0d)", gmii_txen, fifo_rdusedw); else passed++;
    enable = 1'b0;
    wait_frames(1, 300, ok);
    run(30);
    add_frame_exp();
    e = byte_errs();
    checks++; if (!ok || frame_cnt !== 16'd1 || rd_cnt != N) $display("FAIL full_frame: frames=%0d rd=%0d want 1/%0d", frame_cnt, rd_cnt, N); else passed++;
    checks++; if (e != 0 || mem_q.size() != 512 - N) $display("FAIL full_bytes: errors=%0d left=%0d want 0/%0d", e, mem_q.size(), 512 - N); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok; int e;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3 * N; i++) push_word($urandom());
    wait_frames(3, 800, ok);
    checks++; if (!ok || frame_cnt !== 16'd3) $display("FAIL b2b_frames: got %0d want 3", frame_cnt); else passed++;
    checks++; if (rd_cnt != 3 * N || underrun != 0) $display("FAIL b2b_rdreq: got %0d (underrun %0d) want %0d", rd_cnt, underrun, 3 * N); else passed++;
    checks++; if (gap_q.size() != 2) $display("FAIL b2b_gap_count: got %0d want 2", gap_q.size()); else passed++;
    for (int i = 0; i < gap_q.size(); i++) begin
      checks++; if (gap_q[i] != IFG + 1) $display("FAIL b2b_gap%0d: got %0d want %0d", i, gap_q[i], IFG + 1); else passed++;
    end
    for (int i = 0; i < len_q.size(); i++) begin
      checks++; if (len_q[i] != WIRE_LEN) $display("FAIL b2b_len%0d: got %0d want %0d", i, len_q[i], WIRE_LEN); else passed++;
    end
    repeat (3) add_frame_exp();
    e = byte_errs();
    checks++; if (e != 0) $display("FAIL b2b_bytes: %0d errors, got %0d bytes want %0d", e, cap_q.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_enable_gating();
    bit ok; int cyc, e;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3 * N; i++) push_word($urandom());
    wait_frames(1, 300, ok);
    wait_txen(20, ok, cyc);
    run($urandom_range(10, 40));
    enable = 1'b0;
    wait_frames(2, 300, ok);
    run(120);
    checks++; if (!ok || frame_cnt !== 16'd2 || busy !== 1'b0) $display("FAIL gate_frames: got %0d busy=%0b want 2/0", frame_cnt, busy); else passed++;
    checks++; if (rd_cnt != 2 * N || mem_q.size() != N) $display("FAIL gate_reads: rd=%0d left=%0d want %0d/%0d", rd_cnt, mem_q.size(), 2 * N, N); else passed++;
    repeat (2) add_frame_exp();
    e = byte_errs();
    checks++; if (e != 0) $display("FAIL gate_bytes: %0d errors, got %0d bytes want %0d", e, cap_q.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 2 * N; i++) push_word($urandom());
    wait_frames(1, 300, ok);
    wait_txen(20, ok, cyc);
    run(20);
    checks++; if (gmii_txen !== 1'b1 || frame_cnt !== 16'd1) $display("FAIL mid_pre: txen=%0b frames=%0d want 1/1", gmii_txen, frame_cnt); else passed++;
    #2 aclr = 1'b1;
    #1;
    checks++; if (gmii_txen !== 1'b0 || gmii_txd !== 8'h00) $display("FAIL mid_txen: txen=%0b txd=%02h want 0/00", gmii_txen, gmii_txd); else passed++;
    checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0 || fifo_rdreq !== 1'b0) $display("FAIL mid_state: busy=%0b frames=%0d rdreq=%0b want 0/0/0", busy, frame_cnt, fifo_rdreq); else passed++;
    run(2);
    aclr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_threshold();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_gmii_tx.md
# fifo_gmii_tx

Read-side consumer of the 125 MHz Ethernet TX FIFO (32-bit, 512-word dual-clock). It waits until a full burst of payload words is buffered, then drains exactly that burst and serialises it onto an 8-bit GMII transmit interface. Each frame carries a preamble, an SFD, the payload, an optional FCS and an enforced inter-frame gap. It sits between the FIFO's read port and the GMII PHY pins, entirely in the 125 MHz domain.

## Interface
- BURST_WORDS, 15, 32-bit payload words per frame; legal range 15..511, where 15 words = 60-byte Ethernet minimum.
- IFG_CYCLES, 12, minimum idle clocks after a frame, counted from the last active byte.
- clk  in  1  125 MHz clock; also drives the FIFO rdclk.
- aclr  in  1  reset; asynchronous, active-high.
- enable  in  1  permits new frames to start; sampled only in IDLE.
- fifo_q  in  32  FIFO read data; normal (non-show-ahead) mode, valid the clock after fifo_rdreq.
- fifo_rdempty  in  1  FIFO empty flag.
- fifo_rdfull  in  1  FIFO full flag (fifo_rdusedw reads 0 when full).
- fifo_rdusedw  in  9  FIFO occupancy.
- fifo_rdreq  out  1  one-clock read pulse.
- gmii_txd  out  8  transmit byte.
- gmii_txen  out  1  transmit enable.
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0x0000.

## Operation
- Reset values: fifo_rdreq=0, gmii_txd=0x00, gmii_txen=0, busy=0, frame_cnt=0, state=IDLE.
- States: IDLE -> PRE (7 clk) -> SFD (1 clk) -> DATA (4*BURST_WORDS clk) -> FCS (4 clk, FCS_EN only) -> IFG (IFG_CYCLES clk) -> IDLE.
- IDLE start condition:
  - enable=1, and
  - fifo_rdfull=1 or fifo_rdusedw>=BURST_WORDS, and
  - fifo_rdempty=0.
- PRE drives gmii_txd=0x55. SFD drives 0xD5. gmii_txen=1 in PRE, SFD, DATA and FCS.
- DATA byte order is MSB first within each word: q[31:24], q[23:16], q[15:8], q[7:0].
- Read scheduling:
  - The first fifo_rdreq is issued in the 7th PRE cycle.
  - fifo_q is latched into the next-word register in the SFD cycle.
  - For every later word, fifo_rdreq is issued on byte lane 2 of the current word and data is latched on lane 3.
  - No read is issued during the last word.
  - Exactly BURST_WORDS pulses are issued per frame.
- The start condition guarantees no underrun, so fifo_rdempty is not re-checked mid-frame.
- enable falling mid-frame has no effect; the frame and its IFG complete.
- frame_cnt increments on the clock after the last byte (DATA or FCS) with txen high.
- aclr mid-frame: all outputs take their reset values immediately, the frame is truncated, and the FIFO is not re-synchronised. Clearing the FIFO is the system's job.

## Timing
- Start decision at clock t (IDLE): gmii_txen rises with txd=0x55 at t+1.
- SFD at t+8. First payload byte (word0[31:24]) at t+9.
- Frame length on the wire: 8 + 4*BURST_WORDS clocks, plus 4 with FCS_EN.
- gmii_txen low time between frames: at least IFG_CYCLES+1 clocks. The +1 is the IDLE evaluation clock.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- FIFO_GMII_TX_FCS_EN defined:
  - CRC-32 is computed over the payload bytes only: reflected form of polynomial 0x04C11DB7, init 0xFFFFFFFF, final complement.
  - The 4 FCS bytes are sent in the FCS state, least-significant byte of the complemented CRC first.
- Not defined:
  - The FCS state and CRC logic are absent.
  - DATA proceeds directly to IFG; the PHY/MAC downstream appends the FCS.

## Test plan
- **Reset:** reset applied with FIFO preloaded -> all outputs 0, no fifo_rdreq. Release -> first frame starts once conditions hold.
- **Single frame:** BURST_WORDS=15, IFG_CYCLES=12, FIFO loaded with 0x00010203..0x38393A3B -> wire shows 7x0x55, 0xD5, bytes 0x00..0x3B.
  - Exactly 15 fifo_rdreq pulses.
  - frame_cnt=1.
  - txen high 68 clocks, or 72 with FCS_EN.
- **FCS:** with FIFO_GMII_TX_FCS_EN defined, the bench runs a reflected CRC over payload+FCS -> residue 0xDEBB20E3. The 4 FCS bytes match the bench model.
- **Threshold boundary:**
  - fifo_rdusedw=14 -> no start.
  - Writing the 15th word -> txen rises within 1 clock of the condition becoming true.
  - fifo_rdfull=1 with fifo_rdusedw=0 -> frame starts.
- **Back-to-back and gating:**
  - 45 words buffered -> 3 frames, each with a txen-low gap of exactly 13 clocks.
  - enable dropped mid-frame 2 -> frame 2 completes, frame 3 never starts.
- **Reset mid-frame:** aclr pulsed during DATA -> txen=0 immediately, frame_cnt=0, busy=0.
